led_fade_seq: RTL and testbench

Sequencer for the 4-LED PWM output of the board demo. It owns one shared PWM period counter. It ramps a single duty value up and down in glitch-free steps at period boundaries, and walks that fade across the LEDs one at a time (chase) or drives all four together. Start/stop pulses come from the board-level button/debounce logic. `led` drives the pins directly.

---
 rtl/led_fade_seq_pkg.sv | 24 ++
 rtl/led_fade_seq_if.sv | 34 +++
 rtl/led_fade_seq_pwm_period_gen.sv | 37 +++
 rtl/led_fade_seq.sv | 157 +++++++++++++++
 tb/tb_led_fade_seq.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_fade_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED fade sequencer: the sequencer FSM state
// type, the chase/all mode encoding and the board-default timing constants.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HI,
        RAMP_DOWN,
        HOLD_LO
    } seqState_t;

    localparam logic MODE_CHASE = 1'b0;
    localparam logic MODE_ALL   = 1'b1;

    localparam int DEF_PERIOD = 25000;
    localparam int DEF_STEP   = 10;
    localparam int DEF_HOLD   = 50;
    localparam int DEF_CW     = 16;

endpackage

// File: rtl/led_fade_seq_if.sv
// ---------------------------------------------------------------------------
// led_fade_seq_if
// Control/status bundle between the board-level button logic (master) and
// the LED fade sequencer (slave).
//   start, stop, mode_all : requests into the sequencer
//   led, busy, ch_idx     : PWM pins and sequencer status
//   duty, period_tick     : current duty and PWM period boundary strobe
// ---------------------------------------------------------------------------
interface led_fade_seq_if
    import led_seq_pkg::*;
#(
    parameter int CW = DEF_CW
);

    logic          start;
    logic          stop;
    logic          mode_all;
    logic [3:0]    led;
    logic          busy;
    logic [1:0]    ch_idx;
    logic [CW-1:0] duty;
    logic          period_tick;

    modport master (
        output start, stop, mode_all,
        input  led, busy, ch_idx, duty, period_tick
    );

    modport slave (
        input  start, stop, mode_all,
        output led, busy, ch_idx, duty, period_tick
    );

endinterface

// File: rtl/led_fade_seq_pwm_period_gen.sv
// ---------------------------------------------------------------------------
// pwm_period_gen
// Free-running PWM period counter shared by all four LED channels.
//   clk, nrst   : clock, asynchronous active-low reset
//   pcnt        : position inside the current period, 0..PERIOD-1
//   period_tick : high on the last cycle of each period
// ---------------------------------------------------------------------------
module pwm_period_gen #(
    parameter int PERIOD = 25000,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          nrst,
    output logic [CW-1:0] pcnt,
    output logic          period_tick
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_pcnt;

    // Counter runs regardless of sequencer state so the PWM grid is fixed
    // from reset onward.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pcnt <= '0;
        end else if (r_pcnt == LAST) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + CW'(1);
        end
    end

    assign pcnt        = r_pcnt;
    assign period_tick = (r_pcnt == LAST);

endmodule

// File: rtl/led_fade_seq.sv
// ---------------------------------------------------------------------------
// led_fade_seq
// Fades one shared duty value up and down and walks it across four LEDs
// (chase) or applies it to all four at once.
//   clk  : sole clock
//   nrst : asynchronous active-low reset
//   bus  : led_fade_seq_if slave (start/stop/mode_all in; led, busy,
//          ch_idx, duty, period_tick out)
// ---------------------------------------------------------------------------
module led_fade_seq
    import led_seq_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int STEP   = DEF_STEP,
    parameter int HOLD   = DEF_HOLD,
    parameter int CW     = DEF_CW
) (
    input  logic           clk,
    input  logic           nrst,
    led_fade_seq_if.slave  bus
);

    localparam logic [CW:0]   PERIOD_W = (CW+1)'(PERIOD);
    localparam logic [CW:0]   STEP_W   = (CW+1)'(STEP);
    localparam logic [CW:0]   HOLD_W   = (CW+1)'(HOLD);
    localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);

    logic [CW-1:0] w_pcnt;
    logic          w_tick;

    seqState_t     r_state;
    logic [CW-1:0] r_duty;
    logic [CW:0]   r_holdCnt;
    logic [1:0]    r_chIdx;
    logic          r_stopPend;
    logic          r_modeAll;
    logic [3:0]    r_led;

    logic [CW:0]   w_upSum;
    logic [CW:0]   w_dnDiff;
    logic [CW:0]   w_holdNext;
    logic [CW-1:0] w_dutyUp;
    logic [CW-1:0] w_dutyDn;

    pwm_period_gen #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_period (
        .clk         (clk),
        .nrst        (nrst),
        .pcnt        (w_pcnt),
        .period_tick (w_tick)
    );

    // Saturating duty arithmetic is done one bit wider so the sum cannot
    // wrap and the difference's top bit flags an underflow.
    assign w_upSum    = {1'b0, r_duty} + STEP_W;
    assign w_dutyUp   = (w_upSum >= PERIOD_W) ? PERIOD_C : w_upSum[CW-1:0];
    assign w_dnDiff   = {1'b0, r_duty} - STEP_W;
    assign w_dutyDn   = w_dnDiff[CW] ? '0 : w_dnDiff[CW-1:0];
    assign w_holdNext = r_holdCnt + (CW+1)'(1);

    // Sequencer. Everything except the IDLE exit advances only on the
    // period boundary so the PWM shape never changes mid-period. A stop
    // request is parked until the end of the dark hold, so the block only
    // goes idle with the LEDs off.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_duty     <= '0;
            r_holdCnt  <= '0;
            r_chIdx    <= '0;
            r_stopPend <= 1'b0;
            r_modeAll  <= MODE_CHASE;
        end else begin
            if ((r_state != IDLE) && bus.stop) begin
                r_stopPend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_modeAll <= bus.mode_all;
                        r_chIdx   <= '0;
                        r_duty    <= '0;
                        r_state   <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (w_tick) begin
                        r_duty <= w_dutyUp;
                        if (w_dutyUp == PERIOD_C) begin
                            r_holdCnt <= '0;
                            r_state   <= HOLD_HI;
                        end
                    end
                end
                HOLD_HI: begin
                    if (w_tick) begin
                        r_holdCnt <= w_holdNext;
                        if (w_holdNext == HOLD_W) begin
                            r_state <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (w_tick) begin
                        r_duty <= w_dutyDn;
                        if (w_dutyDn == '0) begin
                            r_holdCnt <= '0;
                            r_state   <= HOLD_LO;
                        end
                    end
                end
                HOLD_LO: begin
                    if (w_tick) begin
                        r_holdCnt <= w_holdNext;
                        if (w_holdNext == HOLD_W) begin
                            if (r_stopPend || bus.stop) begin
                                r_stopPend <= 1'b0;
                                r_state    <= IDLE;
                            end else begin
                                if (r_modeAll != MODE_ALL) begin
                                    r_chIdx <= r_chIdx + 2'd1;
                                end
                                r_state <= RAMP_UP;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // PWM compare, registered so the pins are glitch-free; the output lags
    // the pcnt/duty comparison by one clock.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_led <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_led[i] <= (r_state != IDLE)
                         && ((r_modeAll == MODE_ALL) || (r_chIdx == 2'(i)))
                         && (w_pcnt < r_duty);
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.busy        = (r_state != IDLE);
    assign bus.ch_idx      = r_chIdx;
    assign bus.duty        = r_duty;
    assign bus.period_tick = w_tick;

endmodule

// File: tb/tb_led_fade_seq.sv
// ---------------------------------------------------------------------------
// tb_led_fade_seq
// Two sequencer instances with PERIOD=100, HOLD=2: A uses STEP=25 and B
// uses STEP=30 (saturating last step). A schedule-based model predicts
// every output each cycle; directed literals pin the model's key values.
// ---------------------------------------------------------------------------
module tb_led_fade_seq;
    import led_seq_pkg::*;

    localparam int PER   = 100;
    localparam int HLD   = 2;
    localparam int CWB   = 16;
    localparam int STEPA = 25;
    localparam int STEPB = 30;

    logic clk   = 1'b0;
    logic nrstA = 1'b0;
    logic nrstB = 1'b0;

    led_fade_seq_if #(.CW(CWB)) busA();
    led_fade_seq_if #(.CW(CWB)) busB();

    led_fade_seq #(.PERIOD(PER), .STEP(STEPA), .HOLD(HLD), .CW(CWB)) dutA (
        .clk  (clk),
        .nrst (nrstA),
        .bus  (busA)
    );

    led_fade_seq #(.PERIOD(PER), .STEP(STEPB), .HOLD(HLD), .CW(CWB)) dutB (
        .clk  (clk),
        .nrst (nrstB),
        .bus  (busB)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;
    bit chkEn    = 1'b0;

    int         mCyc  [2];
    int         mPos  [2];
    int         mDuty [2];
    int         mCh   [2];
    bit         mBusy [2];
    bit         mAll  [2];
    bit         mStop [2];
    logic [3:0] mLed  [2];

    function automatic int stepOf(input int k);
        return (k == 0) ? STEPA : STEPB;
    endfunction

    function automatic int rampLen(input int s);
        return (PER + s - 1) / s;
    endfunction

    // Duty after the (pos+1)-th period boundary of one channel's fade.
    function automatic int dutyAt(input int s, input int pos);
        int r;
        int v;
        r = rampLen(s);
        if (pos < r) begin
            v = (pos + 1) * s;
            return (v > PER) ? PER : v;
        end
        if (pos < r + HLD) return PER;
        if (pos < 2 * r + HLD) begin
            v = PER - (pos - r - HLD + 1) * s;
            return (v < 0) ? 0 : v;
        end
        return 0;
    endfunction

    task automatic modelReset(input int k);
        mCyc[k]  = 0;
        mPos[k]  = 0;
        mDuty[k] = 0;
        mCh[k]   = 0;
        mBusy[k] = 1'b0;
        mAll[k]  = 1'b0;
        mStop[k] = 1'b0;
        mLed[k]  = 4'b0000;
    endtask

    task automatic modelStep(input int k, input logic st, input logic sp, input logic md);
        int         pc;
        logic [3:0] nl;
        pc = mCyc[k] % PER;
        for (int i = 0; i < 4; i++) begin
            nl[i] = mBusy[k] && (mAll[k] || (mCh[k] == i)) && (pc < mDuty[k]);
        end
        if (!mBusy[k]) begin
            if (st && !sp) begin
                mBusy[k] = 1'b1;
                mPos[k]  = 0;
                mDuty[k] = 0;
                mCh[k]   = 0;
                mAll[k]  = md;
            end
        end else begin
            if (sp) mStop[k] = 1'b1;
            if (pc == PER - 1) begin
                mDuty[k] = dutyAt(stepOf(k), mPos[k]);
                mPos[k]  = mPos[k] + 1;
                if (mPos[k] == 2 * rampLen(stepOf(k)) + 2 * HLD) begin
                    mPos[k] = 0;
                    if (mStop[k]) begin
                        mBusy[k] = 1'b0;
                        mStop[k] = 1'b0;
                    end else if (!mAll[k]) begin
                        mCh[k] = (mCh[k] + 1) % 4;
                    end
                end
            end
        end
        mCyc[k] = mCyc[k] + 1;
        mLed[k] = nl;
    endtask

    // Model advances on the same edges as each DUT, including async reset.
    always @(posedge clk or negedge nrstA) begin
        if (!nrstA) modelReset(0);
        else        modelStep(0, busA.start, busA.stop, busA.mode_all);
    end

    always @(posedge clk or negedge nrstB) begin
        if (!nrstB) modelReset(1);
        else        modelStep(1, busB.start, busB.stop, busB.mode_all);
    end

    task automatic checkInst(input int k, input logic [3:0] led, input logic busy,
                             input logic [1:0] ch, input logic [15:0] duty, input logic tick);
        logic expTick;
        expTick  = ((mCyc[k] % PER) == PER - 1);
        vecCount = vecCount + 1;
        if (led !== mLed[k] || busy !== mBusy[k] || ch !== 2'(mCh[k])
            || duty !== 16'(mDuty[k]) || tick !== expTick) begin
            errCount = errCount + 1;
            $display("[TB] FAIL model%0d t=%0t got led=%b busy=%b ch=%0d duty=%0d tick=%b want led=%b busy=%b ch=%0d duty=%0d tick=%b",
                     k, $time, led, busy, ch, duty, tick,
                     mLed[k], mBusy[k], mCh[k], mDuty[k], expTick);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            checkInst(0, busA.led, busA.busy, busA.ch_idx, busA.duty, busA.period_tick);
            checkInst(1, busB.led, busB.busy, busB.ch_idx, busB.duty, busB.period_tick);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount = vecCount + 1;
        if (actual != expected) begin
            errCount = errCount + 1;
            $display("[TB] FAIL %s t=%0t got %0d want %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic st, input logic sp, input logic md);
        @(negedge clk);
        #1;
        if (k == 0) begin
            busA.start = st; busA.stop = sp; busA.mode_all = md;
        end else begin
            busB.start = st; busB.stop = sp; busB.mode_all = md;
        end
        @(negedge clk);
        #1;
        if (k == 0) begin
            busA.start = 1'b0; busA.stop = 1'b0;
        end else begin
            busB.start = 1'b0; busB.stop = 1'b0;
        end
    endtask

    task automatic waitTick(input int k);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 2 * PER + 10; c++) begin
            @(negedge clk);
            if (((k == 0) ? busA.period_tick : busB.period_tick) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vecCount = vecCount + 1;
            errCount = errCount + 1;
            $display("[TB] FAIL tickTimeout%0d t=%0t got no tick want tick", k, $time);
        end
    endtask

    task automatic nextDuty(input int k, output int d);
        waitTick(k);
        @(negedge clk);
        d = (k == 0) ? int'(busA.duty) : int'(busB.duty);
    endtask

    task automatic alignAfterTick(input int k);
        waitTick(k);
        repeat (3) @(negedge clk);
    endtask

    int expA [12] = '{25, 50, 75, 100, 100, 100, 75, 50, 25, 0, 0, 0};
    int expB [12] = '{30, 60, 90, 100, 100, 100, 70, 40, 10, 0, 0, 0};

    initial begin
        int d;
        int tickCnt;
        busA.start = 1'b0; busA.stop = 1'b0; busA.mode_all = 1'b0;
        busB.start = 1'b0; busB.stop = 1'b0; busB.mode_all = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busA.busy, 0);
        checkOutput("rstDuty", busA.duty, 0);
        checkOutput("rstLed",  busA.led, 0);
        checkOutput("rstTick", busA.period_tick, 0);
        #1;
        nrstA = 1'b1;
        nrstB = 1'b1;
        chkEn = 1'b1;

        $display("[TB] idle run");
        tickCnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (busA.period_tick === 1'b1) tickCnt = tickCnt + 1;
        end
        checkOutput("idleTicks", tickCnt, 5);
        checkOutput("idleBusy", busA.busy, 0);

        $display("[TB] chase channel 0");
        alignAfterTick(0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("busyAfterStart", busA.busy, 1);
        for (int i = 0; i < 12; i++) begin
            nextDuty(0, d);
            checkOutput("dutyA", d, expA[i]);
            if (i == 3) begin
                @(negedge clk);
                checkOutput("led0Full", busA.led, 1);
            end
        end
        checkOutput("chAfterCh0", busA.ch_idx, 1);

        $display("[TB] chase walk");
        for (int r = 2; r <= 4; r++) begin
            repeat (12) nextDuty(0, d);
            checkOutput("chWalk", busA.ch_idx, r % 4);
        end

        $display("[TB] graceful stop");
        nextDuty(0, d);
        nextDuty(0, d);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        for (int i = 3; i <= 12; i++) begin
            nextDuty(0, d);
            if (i == 11) checkOutput("busyBeforeEnd", busA.busy, 1);
            if (i == 12) begin
                checkOutput("busyFalls", busA.busy, 0);
                checkOutput("ledDarkIdle", busA.led, 0);
            end
        end

        $display("[TB] start with stop in idle");
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("startStopIdle", busA.busy, 0);
        repeat (20) @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);

        $display("[TB] all mode");
        alignAfterTick(0);
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        checkOutput("busyAllStart", busA.busy, 1);
        @(negedge clk);
        #1;
        busA.mode_all = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nextDuty(0, d);
            if (i == 3) begin
                @(negedge clk);
                checkOutput("allLedsOn", busA.led, 15);
            end
            if (i == 5) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("allModeCh", busA.ch_idx, 0);
        checkOutput("allModeBusy", busA.busy, 1);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        repeat (12) nextDuty(0, d);
        checkOutput("allModeStopped", busA.busy, 0);

        $display("[TB] saturating step and async reset");
        alignAfterTick(1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            nextDuty(1, d);
            checkOutput("dutyB", d, expB[i]);
        end
        nextDuty(1, d);
        checkOutput("dutyB2a", d, 30);
        nextDuty(1, d);
        checkOutput("dutyB2b", d, 60);
        checkOutput("chB", busB.ch_idx, 1);
        @(negedge clk);
        #3;
        nrstB = 1'b0;
        #1;
        checkOutput("asyncLed",  busB.led, 0);
        checkOutput("asyncDuty", busB.duty, 0);
        checkOutput("asyncBusy", busB.busy, 0);
        @(negedge clk);
        #1;
        nrstB = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("postRstBusy", busB.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
